// File: rtl/line_burst_adaptor_pkg.sv
// Shared types for the cache-to-memory line path: line/beat/address widths and the
// burst adaptor state encoding.
package cache_mem_types;

  localparam int S_LINE      = 256;
  localparam int S_BURST     = 64;
  localparam int S_ADDR      = 32;
  localparam int NUM_BURSTS  = S_LINE / S_BURST;
  localparam int BEAT_BITS   = $clog2(NUM_BURSTS);
  localparam int OFFSET_BITS = $clog2(S_LINE / 8);

  typedef logic [S_LINE-1:0]    line_t;
  typedef logic [S_BURST-1:0]   burst_t;
  typedef logic [S_ADDR-1:0]    addr_t;
  typedef logic [BEAT_BITS-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } adaptor_state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// Moves whole cache lines to/from memory as fixed-length bursts: collects read beats into
// a fill line, or serialises a latched dirty line into write beats.
module line_burst_adaptor
  import cache_mem_types::*;
#(
  parameter int s_line  = S_LINE,
  parameter int s_burst = S_BURST,
  parameter int s_addr  = S_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic [s_addr-1:0]   address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [s_addr-1:0]   address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int num_bursts  = s_line / s_burst;
  localparam int beat_bits   = $clog2(num_bursts);
  localparam int offset_bits = $clog2(s_line / 8);

  localparam logic [beat_bits-1:0] last_beat = beat_bits'(num_bursts - 1);
  localparam logic [s_addr-1:0]    addr_mask = ~((s_addr'(1) << offset_bits) - s_addr'(1));

  adaptor_state_t       state, state_next;
  logic [beat_bits-1:0] k;
  logic [s_line-1:0]    wr_line;

  // NOTE: every sequential assignment is non-blocking so all registers update from the
  // same pre-edge values; blocking here would let k's new value leak into the line write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      // NOTE: the data registers are reset too, because line_o and burst_o have defined
      // reset values that the cache can observe; pure storage would not need it.
      line_o    <= '0;
      wr_line   <= '0;
      address_o <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (write_i) begin
            wr_line   <= line_i;
            address_o <= address_i & addr_mask;
          end else if (read_i) begin
            address_o <= address_i & addr_mask;
          end
        end
        RD: begin
          if (resp_i) begin
            line_o[k*s_burst +: s_burst] <= burst_i;
            k <= k + 1'b1;
          end
        end
        WR: begin
          if (resp_i) k <= k + 1'b1;
        end
        DONE: k <= '0;
        default: k <= '0;
      endcase
    end
  end

  // Write beat tracks the beat counter, so it advances the cycle after each ack.
  assign burst_o = wr_line[k*s_burst +: s_burst];

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    unique case (state)
      IDLE: begin
        if (write_i)     state_next = WR;
        else if (read_i) state_next = RD;
      end
      RD: begin
        read_o = 1'b1;
        if (resp_i && (k == last_beat)) state_next = DONE;
      end
      WR: begin
        write_o = 1'b1;
        if (resp_i && (k == last_beat)) state_next = DONE;
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: table-driven line transfers with a
// scoreboard, plus hand-written reset-abort, priority and spurious-ack sequences.
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  line_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [255:0] last_fill;

  typedef struct {
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] line;
    int           gap;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete line transfer; called and returns at a negative clock edge.
  task automatic run_txn(input bit is_wr, input logic [31:0] addr, input logic [255:0] line,
                         input int gap, input logic [31:0] exp_addr);
    logic [1:0] dir;
    bit found;
    dir = is_wr ? 2'b01 : 2'b10;
    address_i = addr;
    if (is_wr) begin
      line_i  = line;
      write_i = 1'b1;
      for (int b = 0; b < 4; b++) exp_beat_q.push_back(line[b*64 +: 64]);
    end else begin
      read_i = 1'b1;
      exp_line_q.push_back(line);
    end
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read_o || write_o) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      check("request_timeout", 256'(0), 256'(1));
      exp_line_q.delete();
      exp_beat_q.delete();
      read_i  = 1'b0;
      write_i = 1'b0;
      return;
    end
    check("address_o", 256'(address_o), 256'(exp_addr));
    check("direction", 256'({read_o, write_o}), 256'(dir));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        resp_i = 1'b0;
        @(negedge clk);
        check("stall_direction", 256'({read_o, write_o}), 256'(dir));
        check("stall_resp_o", 256'(resp_o), 256'(0));
        if (is_wr) check("stall_burst_o", 256'(burst_o), 256'(exp_beat_q[0]));
      end
      if (is_wr) check("burst_o", 256'(burst_o), 256'(exp_beat_q.pop_front()));
      resp_i  = 1'b1;
      burst_i = is_wr ? 64'(32'($urandom)) : line[b*64 +: 64];
      @(negedge clk);
      resp_i = 1'b0;
      if (b < 3) begin
        check("busy_direction", 256'({read_o, write_o}), 256'(dir));
        check("busy_resp_o", 256'(resp_o), 256'(0));
      end
    end
    check("done_resp_o", 256'(resp_o), 256'(1));
    check("done_direction", 256'({read_o, write_o}), 256'(0));
    if (!is_wr) begin
      check("line_o", line_o, exp_line_q.pop_front());
      last_fill = line;
    end
    if (is_wr) write_i = 1'b0;
    else       read_i  = 1'b0;
    @(negedge clk);
    check("resp_pulse_end", 256'(resp_o), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{is_wr: 1'b0, addr: 32'h0000_1234, gap: 0, exp_addr: 32'h0000_1220,
                line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{is_wr: 1'b1, addr: 32'h8000_0040, gap: 0, exp_addr: 32'h8000_0040,
                line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}};
    vecs[2] = '{is_wr: 1'b0, addr: 32'h0000_1234, gap: 3, exp_addr: 32'h0000_1220,
                line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[3] = '{is_wr: 1'b1, addr: 32'hFFFF_FFFF, gap: 1, exp_addr: 32'hFFFF_FFE0,
                line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978}};
    vecs[4] = '{is_wr: 1'b0, addr: 32'h0000_001F, gap: 2, exp_addr: 32'h0000_0000,
                line: {64'h8000_0000_0000_0001, 64'h7777_0000_7777_0000,
                       64'h0000_FFFF_0000_FFFF, 64'h5A5A_A5A5_5A5A_A5A5}};

    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0; last_fill = '0;
    repeat (3) @(negedge clk);
    check("reset_read_o", 256'(read_o), 256'(0));
    check("reset_write_o", 256'(write_o), 256'(0));
    check("reset_resp_o", 256'(resp_o), 256'(0));
    check("reset_line_o", line_o, 256'(0));
    check("reset_burst_o", 256'(burst_o), 256'(0));
    check("reset_address_o", 256'(address_o), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].is_wr, vecs[i].addr, vecs[i].line, vecs[i].gap, vecs[i].exp_addr);

    // Simultaneous requests: write-back first, then the held read starts the fill.
    read_i = 1'b1;
    run_txn(1'b1, 32'h0000_4567, vecs[3].line, 0, 32'h0000_4560);
    run_txn(1'b0, 32'h0000_4567, vecs[4].line, 0, 32'h0000_4560);

    // Reset two beats into a fill aborts it without a response.
    address_i = 32'h0000_2468;
    read_i    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read_o) break;
    end
    check("abort_fill_started", 256'(read_o), 256'(1));
    for (int b = 0; b < 2; b++) begin
      resp_i  = 1'b1;
      burst_i = vecs[0].line[b*64 +: 64];
      @(negedge clk);
    end
    resp_i = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check("abort_read_o", 256'(read_o), 256'(0));
    check("abort_line_o", line_o, 256'(0));
    check("abort_resp_o", 256'(resp_o), 256'(0));
    check("abort_address_o", 256'(address_o), 256'(0));
    rst    = 1'b0;
    read_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", 256'({resp_o, read_o, write_o}), 256'(0));
    end
    run_txn(1'b0, 32'h0000_2468, vecs[0].line, 0, 32'h0000_2460);

    // Spurious acknowledges while idle change nothing.
    for (int i = 0; i < 5; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      @(negedge clk);
      check("idle_ack_outputs", 256'({resp_o, read_o, write_o}), 256'(0));
      check("idle_ack_line_o", line_o, last_fill);
    end
    resp_i = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
